uart_rx_byte: RTL and testbench

UART receive front end that deserialises 8N1 frames from the `rxd` pin into bytes. It drives the `rx_data`/`rx_busy` pair consumed by the UART-to-SDRAM receive controller. That controller latches `rx_data` on the falling edge of `rx_busy` and packs byte pairs into 16-bit SDRAM write words.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_byte_if.sv | 29 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx_byte.sv | 131 +++++++++++++
 tb/tb_uart_rx_byte.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud divider helper
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP,
    UART_WAIT_IDLE
  } uart_state_e;

  // Clock cycles per bit, integer-truncated
  function automatic int baud_div(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// rtl/uart_rx_byte_if.sv - serial line in, received byte and status out
interface uart_rx_byte_if;
  import uart_pkg::*;

  logic                      rxd;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_busy;
  logic                      rx_done;
  logic                      rx_err;

  // Receiver side: consumes the line, produces byte and status
  modport master (
    input  rxd,
    output rx_data,
    output rx_busy,
    output rx_done,
    output rx_err
  );

  // Line driver / byte consumer side
  modport slave (
    output rxd,
    input  rx_data,
    input  rx_busy,
    input  rx_done,
    input  rx_err
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for one asynchronous bit
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two register stages to settle metastability before use
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver delivering bytes with busy/done/err
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic           SYS_CLK,
  input  logic           RST,
  uart_rx_byte_if.master rx_if
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam int BIT_W    = $clog2(UART_DATA_BITS);

  // Counter reloads are one less than the interval: sampling happens at zero
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_LOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(UART_DATA_BITS - 1);

  logic                      rxd_s;
  logic                      rxd_d_q;
  uart_state_e               state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [BIT_W-1:0]          bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] shift_d;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      err_q;
  logic                      sample;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync_rxd (
    .clk_i(SYS_CLK),
    .rst_i(RST),
    .d_i  (rx_if.rxd),
    .q_o  (rxd_s)
  );

  assign sample = (cnt_q == '0);

  // Line is LSB first: new bits enter at the top and shift down
  always_comb begin
    shift_d = {rxd_s, shift_q[UART_DATA_BITS-1:1]};
  end

  // Receive FSM with registered byte, busy and one-cycle done/err pulses
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state_q <= UART_IDLE;
      rxd_d_q <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rxd_d_q <= rxd_s;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        UART_IDLE: begin
          if (!rxd_s && rxd_d_q) begin
            cnt_q   <= HALF_LOAD;
            state_q <= UART_START;
          end
        end
        UART_START: begin
          if (sample) begin
            if (!rxd_s) begin
              cnt_q   <= BAUD_LOAD;
              bit_q   <= '0;
              state_q <= UART_DATA;
            end else begin
              state_q <= UART_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        UART_DATA: begin
          // Busy rises one edge after the confirmed start sample
          busy_q <= 1'b1;
          if (sample) begin
            shift_q <= shift_d;
            cnt_q   <= BAUD_LOAD;
            if (bit_q == LAST_BIT) begin
              state_q <= UART_STOP;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        UART_STOP: begin
          if (sample) begin
            // Deliver even on framing error to keep downstream byte pairing
            data_q  <= shift_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= !rxd_s;
            state_q <= rxd_s ? UART_IDLE : UART_WAIT_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        UART_WAIT_IDLE: begin
          // A held-low line (break) must return high before the next start
          if (rxd_s) begin
            state_q <= UART_IDLE;
          end
        end
        default: state_q <= UART_IDLE;
      endcase
    end
  end

  assign rx_if.rx_data = data_q;
  assign rx_if.rx_busy = busy_q;
  assign rx_if.rx_done = done_q;
  assign rx_if.rx_err  = err_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - scoreboard bench for uart_rx_byte at 10 clocks per bit
module tb_uart_rx_byte;

  localparam int BD = 10;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  exp_t exp_q[$];

  int         busy_hi_cnt = 0;
  int         fall_cnt = 0;
  logic       busy_prev = 1'b0;
  logic       pk_half = 1'b0;
  logic [7:0] pk_lo = 8'h00;
  logic [15:0] last_word = 16'h0000;
  int         word_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_byte_if u_if ();

  uart_rx_byte #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000)
  ) dut (
    .SYS_CLK(clk),
    .RST    (rst),
    .rx_if  (u_if)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every rx_done; also models the pairing controller
  always @(negedge clk) begin : monitor
    exp_t e;
    if (u_if.rx_err) check("err_has_done", 32'(u_if.rx_done), 32'd1);
    if (u_if.rx_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", 32'(u_if.rx_data), 32'(e.data));
        check("sb_err", 32'(u_if.rx_err), 32'(e.err));
        check("sb_done_cycle", 32'(cyc), 32'(e.cyc));
        check("sb_busy_low_at_done", 32'(u_if.rx_busy), 32'd0);
      end
    end
    if (u_if.rx_busy) busy_hi_cnt++;
    if (rst) begin
      pk_half = 1'b0;
    end else if (busy_prev && !u_if.rx_busy) begin
      fall_cnt++;
      if (!pk_half) begin
        pk_lo   = u_if.rx_data;
        pk_half = 1'b1;
      end else begin
        last_word = {u_if.rx_data, pk_lo};
        word_cnt++;
        pk_half = 1'b0;
      end
    end
    busy_prev = u_if.rx_busy;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic drive_bit(input logic b, input int n);
    u_if.rxd = b;
    tick(n);
  endtask

  // Pin falls now; sync adds 2 edges, so t0 = now+3 and delivery = t0+95
  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    exp_t e;
    e.data = d;
    e.err  = !stop_b;
    e.cyc  = cyc + 98;
    exp_q.push_back(e);
    drive_bit(1'b0, BD);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BD);
    drive_bit(stop_b, BD);
  endtask

  initial begin : stim
    int t0;
    int h0;
    int f0;
    int w0;
    u_if.rxd = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("reset_rx_data", 32'(u_if.rx_data), 32'h00);
    check("reset_rx_busy", 32'(u_if.rx_busy), 32'd0);
    check("reset_rx_done", 32'(u_if.rx_done), 32'd0);
    check("reset_rx_err", 32'(u_if.rx_err), 32'd0);
    tick(5);

    // Frame 0xA5 with cycle-exact busy checks
    t0 = cyc + 3;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_cyc(t0 + 5);
        check("a5_busy_low_t5", 32'(u_if.rx_busy), 32'd0);
        wait_cyc(t0 + 6);
        check("a5_busy_high_t6", 32'(u_if.rx_busy), 32'd1);
        wait_cyc(t0 + 94);
        check("a5_busy_high_t94", 32'(u_if.rx_busy), 32'd1);
        check("a5_no_done_t94", 32'(u_if.rx_done), 32'd0);
        wait_cyc(t0 + 95);
        check("a5_busy_low_t95", 32'(u_if.rx_busy), 32'd0);
        check("a5_done_t95", 32'(u_if.rx_done), 32'd1);
        check("a5_data_t95", 32'(u_if.rx_data), 32'hA5);
        wait_cyc(t0 + 96);
        check("a5_done_one_cycle", 32'(u_if.rx_done), 32'd0);
      end
    join
    tick(15);

    // 3-cycle glitch must not start a frame
    h0 = busy_hi_cnt;
    drive_bit(1'b0, 3);
    u_if.rxd = 1'b1;
    tick(20);
    check("glitch_no_busy", 32'(busy_hi_cnt - h0), 32'd0);
    check("glitch_data_held", 32'(u_if.rx_data), 32'hA5);

    // Back-to-back frames, no idle between stop and next start
    f0 = fall_cnt;
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    tick(5);
    check("b2b_two_busy_falls", 32'(fall_cnt - f0), 32'd2);
    tick(10);

    // Framing error: stop bit 0 then line held low 30 more cycles
    send_frame(8'h55, 1'b0);
    h0 = busy_hi_cnt;
    tick(30);
    check("break_no_new_frame", 32'(busy_hi_cnt - h0), 32'd0);
    check("break_data_held", 32'(u_if.rx_data), 32'h55);
    u_if.rxd = 1'b1;
    tick(20);

    // Reset during data bit 4, frame discarded
    drive_bit(1'b0, BD);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, BD);
    drive_bit(1'b1, 5);
    check("pre_reset_busy", 32'(u_if.rx_busy), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_rx_data", 32'(u_if.rx_data), 32'h00);
    check("midrst_rx_busy", 32'(u_if.rx_busy), 32'd0);
    check("midrst_rx_done", 32'(u_if.rx_done), 32'd0);
    check("midrst_rx_err", 32'(u_if.rx_err), 32'd0);
    tick(20);
    send_frame(8'h81, 1'b1);
    tick(10);

    // Pairing controller: 0x34 then 0x12 packs to 16'h1234
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(5);
    w0 = word_cnt;
    send_frame(8'h34, 1'b1);
    send_frame(8'h12, 1'b1);
    tick(10);
    check("pair_word_count", 32'(word_cnt - w0), 32'd1);
    check("pair_word_value", 32'(last_word), 32'h1234);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
